// File: rtl/tqvp_reg_arbiter.sv
// rtl/tqvp_reg_arbiter.sv - two-requester round-robin arbiter for the byte-wide peripheral register port
module tqvp_reg_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  input  logic [1:0]          req_lock,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [ADDR_W-1:0]   address,
  output logic                data_write,
  output logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W-1:0]   data_out,
  output logic                busy,
  output logic                owner
);

  // Wide enough to hold LOCK_MAX itself, the saturation point of a tenure.
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_RESP,
    ST_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              write_q, write_d;
  logic              data_write_q, data_write_d;

  logic              winner;
  logic              accept;
  logic              sel;
  logic [1:0]        ready;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Round-robin pick: a lone requester wins, on contention the one not served last wins
  always_comb begin
    winner = 1'b0;
    case (req_valid)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_owner_q;
      default: winner = 1'b0;
    endcase
  end

  // Payload mux for whichever requester is being accepted
  always_comb begin
    sel_addr  = sel ? req_addr[ADDR_W +: ADDR_W]  : req_addr[0 +: ADDR_W];
    sel_wdata = sel ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
  end

  // Next-state logic: accept in IDLE/HOLD, drive peripheral in XFER, respond in RESP
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    lock_cnt_d   = lock_cnt_q;
    address_d    = address_q;
    data_in_d    = data_in_q;
    write_d      = write_q;
    rdata_d      = rdata_q;
    data_write_d = 1'b0;
    accept       = 1'b0;
    sel          = winner;
    ready        = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          accept     = 1'b1;
          sel        = winner;
          lock_cnt_d = CNT_W'(1);
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        // Writes report zero read data so the requester never sees stale bytes.
        rdata_d = write_q ? '0 : data_out;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (req_lock[owner_q] && (lock_cnt_q < CNT_W'(LOCK_MAX))) begin
          state_d = ST_HOLD;
        end else begin
          last_owner_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // Only the lock holder may proceed; dropping the lock hands the port back.
        if (!req_lock[owner_q]) begin
          last_owner_d = owner_q;
          state_d      = ST_IDLE;
        end else if (req_valid[owner_q]) begin
          accept     = 1'b1;
          sel        = owner_q;
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
          state_d    = ST_XFER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      ready[sel]   = 1'b1;
      owner_d      = sel;
      address_d    = sel_addr;
      data_in_d    = sel_wdata;
      write_d      = req_write[sel];
      // Strobe is registered so it lines up with the XFER cycle only.
      data_write_d = req_write[sel];
    end
  end

  // State register and registered peripheral-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      lock_cnt_q   <= '0;
      address_q    <= '0;
      data_in_q    <= '0;
      write_q      <= 1'b0;
      data_write_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      address_q    <= address_d;
      data_in_q    <= data_in_d;
      write_q      <= write_d;
      data_write_q <= data_write_d;
      rdata_q      <= rdata_d;
    end
  end

  assign req_ready  = ready;
  assign rsp_valid  = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata  = (state_q == ST_RESP) ? rdata_q : '0;
  assign address    = address_q;
  assign data_in    = data_in_q;
  assign data_write = data_write_q;
  assign busy       = (state_q != ST_IDLE);
  assign owner      = owner_q;

endmodule

// File: tb/tb_tqvp_reg_arbiter.sv
// tb/tb_tqvp_reg_arbiter.sv - scoreboard bench for tqvp_reg_arbiter
module tb_tqvp_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_write = '0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_lock = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [3:0]  address;
  logic        data_write;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        busy;
  logic        owner;

  tqvp_reg_arbiter #(.ADDR_W(4), .DATA_W(8), .LOCK_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_lock(req_lock), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .address(address),
    .data_write(data_write), .data_in(data_in), .data_out(data_out),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; logic [3:0] addr; logic [7:0] data; bit lock; int gap; } tx_t;
  typedef struct { logic [7:0] rdata; int cyc; } rsp_t;
  typedef struct { logic [3:0] addr; logic [7:0] data; int cyc; } wr_t;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic tx_t mk(bit wr, logic [3:0] a, logic [7:0] d, bit l, int g);
    tx_t t;
    t.wr = wr; t.addr = a; t.data = d; t.lock = l; t.gap = g;
    return t;
  endfunction

  // Peripheral: simple register file, combinational read, write on strobe
  logic [7:0] periph_mem [16];
  assign data_out = periph_mem[address];
  initial begin
    for (int i = 0; i < 16; i++) periph_mem[i] = 8'(i * 29 + 7);
    forever begin
      @(negedge clk);
      if (data_write) periph_mem[address] = data_in;
    end
  end

  // Stimulus queues, filled by the test sequence and drained by the driver
  tx_t txq [2][$];
  int  acc_cnt [2];

  // Driver: present head of each queue, hold until accepted, lock tail after locked tx
  int rd [2];
  int popped [2];
  int tail [2];
  int gap_left [2];
  bit armed [2];
  initial begin
    logic [1:0]  vv, ww, ll;
    logic [7:0]  aa;
    logic [15:0] dd;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 0; popped[i] = 0; tail[i] = 0; gap_left[i] = 0; armed[i] = 0;
    end
    aa = '0; dd = '0;
    forever begin
      @(posedge clk); #1;
      vv = '0; ww = '0; ll = '0;
      for (int i = 0; i < 2; i++) begin
        if (acc_cnt[i] != popped[i]) begin
          popped[i]++;
          tail[i] = txq[i][rd[i]].lock ? 2 : 0;
          rd[i]++;
          armed[i] = 0;
        end
        if (rd[i] < txq[i].size() && !armed[i]) begin
          gap_left[i] = txq[i][rd[i]].gap;
          armed[i] = 1;
        end
        if (rd[i] < txq[i].size() && gap_left[i] == 0) begin
          vv[i] = 1'b1;
          ww[i] = txq[i][rd[i]].wr;
          ll[i] = txq[i][rd[i]].lock;
          aa[i*4 +: 4] = txq[i][rd[i]].addr;
          dd[i*8 +: 8] = txq[i][rd[i]].data;
        end else begin
          ll[i] = (tail[i] > 0);
          if (gap_left[i] > 0 && rd[i] < txq[i].size()) gap_left[i]--;
        end
        if (tail[i] > 0) tail[i]--;
      end
      req_valid = vv; req_write = ww; req_lock = ll; req_addr = aa; req_wdata = dd;
    end
  end

  // Monitor / scoreboard: record grants, predict responses from a register-file model
  int         cyc = 0;
  logic [7:0] model_mem [16];
  rsp_t       exp_rsp [2][$];
  wr_t        exp_wr [$];
  int         grant_id [$];
  int         grant_cyc [$];
  initial begin
    rsp_t r;
    wr_t  w;
    logic [3:0] a;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'(i * 29 + 7);
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_rsp[0].delete(); exp_rsp[1].delete(); exp_wr.delete();
        for (int i = 0; i < 16; i++) model_mem[i] = periph_mem[i];
        continue;
      end
      if (req_ready != 2'b00) begin
        check("ready_onehot", 32'($countones(req_ready)), 32'(1));
        check("ready_without_valid", 32'(req_ready & ~req_valid), 32'(0));
        for (int i = 0; i < 2; i++) begin
          if (req_ready[i]) begin
            a = req_addr[i*4 +: 4];
            d = req_wdata[i*8 +: 8];
            if (req_write[i]) begin
              model_mem[a] = d;
              w.addr = a; w.data = d; w.cyc = cyc;
              exp_wr.push_back(w);
              r.rdata = 8'h00;
            end else begin
              r.rdata = model_mem[a];
            end
            r.cyc = cyc;
            exp_rsp[i].push_back(r);
            grant_id.push_back(i);
            grant_cyc.push_back(cyc);
            acc_cnt[i]++;
          end
        end
      end
      if (data_write) begin
        check("write_expected", 32'(exp_wr.size() > 0), 32'(1));
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          check("write_addr", 32'(address), 32'(w.addr));
          check("write_data", 32'(data_in), 32'(w.data));
          check("write_latency", 32'(cyc - w.cyc), 32'(1));
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (rsp_valid[i]) begin
          check("rsp_expected", 32'(exp_rsp[i].size() > 0), 32'(1));
          if (exp_rsp[i].size() > 0) begin
            r = exp_rsp[i].pop_front();
            check("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
            check("rsp_latency", 32'(cyc - r.cyc), 32'(2));
          end
        end
      end
    end
  end

  task automatic wait_idle(string name, int limit);
    int n = 0;
    while (n < limit && !(rd[0] == txq[0].size() && rd[1] == txq[1].size() && !busy &&
                          exp_rsp[0].size() == 0 && exp_rsp[1].size() == 0)) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, 32'(n < limit), 32'(1));
    repeat (3) @(negedge clk);
  endtask

  task automatic check_order(string name, int base, int exp_ids [$]);
    check({name, "_count"}, 32'(grant_id.size() - base), 32'(exp_ids.size()));
    for (int k = 0; k < exp_ids.size(); k++)
      if (base + k < grant_id.size())
        check({name, "_id"}, 32'(grant_id[base + k]), 32'(exp_ids[k]));
  endtask

  // Test sequence
  initial begin
    int base;
    int n;
    int ids [$];

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
    check("rst_address", 32'(address), 32'(0));
    check("rst_data_write", 32'(data_write), 32'(0));
    check("rst_data_in", 32'(data_in), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_owner", 32'(owner), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Both valid continuously, no lock: alternate grants, 3 cycles apart
    base = grant_id.size();
    txq[0].push_back(mk(1'b1, 4'd1, 8'h11, 1'b0, 0));
    txq[1].push_back(mk(1'b0, 4'd2, 8'h00, 1'b0, 0));
    txq[0].push_back(mk(1'b0, 4'd1, 8'h00, 1'b0, 0));
    txq[1].push_back(mk(1'b1, 4'd2, 8'h22, 1'b0, 0));
    wait_idle("t3", 200);
    ids = '{0, 1, 0, 1};
    check_order("t3", base, ids);
    for (int k = 1; k < 4; k++)
      if (base + k < grant_cyc.size())
        check("t3_spacing", 32'(grant_cyc[base + k] - grant_cyc[base + k - 1]), 32'(3));

    // Single write from requester 0
    txq[0].push_back(mk(1'b1, 4'd3, 8'hA5, 1'b0, 0));
    wait_idle("t1", 200);
    check("t1_periph", 32'(periph_mem[3]), 32'(8'hA5));

    // Read-back through requester 1
    txq[0].push_back(mk(1'b1, 4'd5, 8'h3C, 1'b0, 0));
    wait_idle("t2a", 200);
    txq[1].push_back(mk(1'b0, 4'd5, 8'h00, 1'b0, 0));
    wait_idle("t2b", 200);

    // Locked burst of 10 from requester 0 with requester 1 waiting
    base = grant_id.size();
    for (int k = 0; k < 10; k++)
      txq[0].push_back(mk(1'b1, 4'(6 + k % 8), 8'($urandom), 1'b1, 0));
    txq[1].push_back(mk(1'b0, 4'd9, 8'h00, 1'b0, 0));
    wait_idle("t4", 400);
    ids = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    check_order("t4", base, ids);

    // Lock dropped in HOLD: waiting requester 1 granted the cycle after release
    base = grant_id.size();
    txq[0].push_back(mk(1'b1, 4'd7, 8'($urandom), 1'b1, 0));
    txq[1].push_back(mk(1'b0, 4'd2, 8'h00, 1'b0, 1));
    wait_idle("t5", 200);
    ids = '{0, 1};
    check_order("t5", base, ids);
    if (base + 1 < grant_cyc.size())
      check("t5_release_gap", 32'(grant_cyc[base + 1] - grant_cyc[base]), 32'(4));

    // Reset during XFER of a write
    txq[0].push_back(mk(1'b0, 4'd0, 8'h00, 1'b0, 0));
    wait_idle("t6a", 200);
    base = grant_id.size();
    txq[0].push_back(mk(1'b1, 4'd3, 8'h11, 1'b0, 0));
    n = 0;
    while (grant_id.size() == base && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_accepted", 32'(grant_id.size() - base), 32'(1));
    @(posedge clk); #1;
    check("t6_strobe_before_reset", 32'(data_write), 32'(1));
    rst_n = 1'b0;
    #1;
    check("t6_strobe_in_reset", 32'(data_write), 32'(0));
    check("t6_busy_in_reset", 32'(busy), 32'(0));
    check("t6_rsp_in_reset", 32'(rsp_valid), 32'(0));
    check("t6_addr_in_reset", 32'(address), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_write_dropped", 32'(periph_mem[3]), 32'(8'hA5));
    base = grant_id.size();
    txq[1].push_back(mk(1'b0, 4'd3, 8'h00, 1'b0, 0));
    txq[0].push_back(mk(1'b0, 4'd3, 8'h00, 1'b0, 0));
    wait_idle("t6b", 200);
    ids = '{0, 1};
    check_order("t6", base, ids);

    // Randomized traffic, checked by the scoreboard
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 2; i++)
        txq[i].push_back(mk(1'($urandom), 4'($urandom), 8'($urandom),
                            ($urandom_range(3) == 0), $urandom_range(3)));
    end
    wait_idle("rand", 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
